// File: rtl/regfile_pkg.sv
// Shared constants, address type and one-hot decode for the register file.
// Contents: RF_WIDTH/RF_DEPTH/RF_ZERO_REG defaults, rf_addr_t, rf_onehot().
package regfile_pkg;

    localparam int RF_WIDTH    = 64;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = 31;

    // Widest decode supported; callers cast the result down to DEPTH bits.
    localparam int RF_MAX_AW    = 8;
    localparam int RF_MAX_DEPTH = 1 << RF_MAX_AW;

    typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;
    typedef logic [RF_MAX_AW-1:0]        rf_wide_addr_t;

    function automatic logic [RF_MAX_DEPTH-1:0] rf_onehot(
        input rf_wide_addr_t addr
    );
        logic [RF_MAX_DEPTH-1:0] dec;
        dec       = '0;
        dec[addr] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Register-file bus: writeback port, scoreboard set, read ports, busy state.
// master = datapath side, slave = regfile_bypass.
interface regfile_bypass_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [WIDTH-1:0]             wr_data;
    logic [NUM_RD*AW-1:0]         rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         sb_set_en;
    logic [AW-1:0]                sb_set_addr;
    logic [DEPTH-1:0]             busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        output sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  sb_set_en, sb_set_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_entry.sv
// One register: WIDTH-bit data plus its pending-write scoreboard bit.
// Ports: clk, rst_n, we_i, set_i, wdata_i -> q_o (data), busy_o (pending).
module regfile_entry
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic             set_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;

    // A new producer issuing on the edge its predecessor retires
    // keeps the register pending: set beats clear.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q & ~we_i;
        if (we_i) begin
            data_d = wdata_i;
        end
        if (set_i) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign q_o    = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_bypass.sv
// Register file with zero register, write-to-read bypass and scoreboard.
// Ports: clk, rst_n (async, active low), bus (regfile_bypass_if.slave).
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_bypass_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0]            wr_dec;
    logic [DEPTH-1:0]            set_dec;
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;

    assign wr_dec = bus.wr_en
        ? DEPTH'(rf_onehot(RF_MAX_AW'(bus.wr_addr)))
        : '0;

    assign set_dec = bus.sb_set_en
        ? DEPTH'(rf_onehot(RF_MAX_AW'(bus.sb_set_addr)))
        : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        if (i == ZERO_REG) begin : g_zero
            // Writes and sets to the zero register fall away here.
            logic unused_dec;
            assign unused_dec = wr_dec[i] ^ set_dec[i];
            assign regs[i]    = '0;
            assign busy[i]    = 1'b0;
        end else begin : g_reg
            regfile_entry #(
                .WIDTH (WIDTH)
            ) u_entry (
                .clk     (clk),
                .rst_n   (rst_n),
                .we_i    (wr_dec[i]),
                .set_i   (set_dec[i]),
                .wdata_i (bus.wr_data),
                .q_o     (regs[i]),
                .busy_o  (busy[i])
            );
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic             is_zero;
        logic             hit;
        logic [WIDTH-1:0] data;
        logic             bsy;

        assign ra      = bus.rd_addr[p*AW +: AW];
        assign is_zero = (ra == AW'(ZERO_REG));
        assign hit     = (BYPASS != 0) && bus.wr_en
                         && (ra == bus.wr_addr);

        // Zero register outranks the bypass; a forwarded value
        // is never reported as still pending.
        always_comb begin
            data = regs[ra];
            bsy  = busy[ra];
            if (is_zero) begin
                data = '0;
                bsy  = 1'b0;
            end else if (hit) begin
                data = bus.wr_data;
                bsy  = 1'b0;
            end
        end

        assign bus.rd_data[p] = data;
        assign bus.rd_busy[p] = bsy;
    end

    assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed and model-checked bench for regfile_bypass.
// DUTs: A (64x32, 2 rd, bypass), B (same, no bypass), C (32x16, 3 rd, bypass).
module tb_regfile_bypass;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Shared stimulus for A and B
    logic           we;
    logic [4:0]     wa;
    logic [63:0]    wd;
    logic [1:0][4:0] ra;
    logic           se;
    logic [4:0]     sa;

    // Stimulus for C
    logic           cwe;
    logic [3:0]     cwa;
    logic [31:0]    cwd;
    logic [2:0][3:0] cra;
    logic           cse;
    logic [3:0]     csa;

    regfile_bypass_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2)) ifa ();
    regfile_bypass_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2)) ifb ();
    regfile_bypass_if #(.WIDTH(32), .DEPTH(16), .NUM_RD(3)) ifc ();

    assign ifa.wr_en       = we;
    assign ifa.wr_addr     = wa;
    assign ifa.wr_data     = wd;
    assign ifa.rd_addr     = ra;
    assign ifa.sb_set_en   = se;
    assign ifa.sb_set_addr = sa;

    assign ifb.wr_en       = we;
    assign ifb.wr_addr     = wa;
    assign ifb.wr_data     = wd;
    assign ifb.rd_addr     = ra;
    assign ifb.sb_set_en   = se;
    assign ifb.sb_set_addr = sa;

    assign ifc.wr_en       = cwe;
    assign ifc.wr_addr     = cwa;
    assign ifc.wr_data     = cwd;
    assign ifc.rd_addr     = cra;
    assign ifc.sb_set_en   = cse;
    assign ifc.sb_set_addr = csa;

    regfile_bypass #(
        .WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    regfile_bypass #(
        .WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    regfile_bypass #(
        .WIDTH(32), .DEPTH(16), .NUM_RD(3), .ZERO_REG(15), .BYPASS(1)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Reference state
    logic [63:0] m_ab [32];
    logic [31:0] b_ab;
    logic [31:0] m_c  [16];
    logic [15:0] b_c;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = '0; wd = '0; ra = '0; se = 1'b0; sa = '0;
        cwe = 1'b0; cwa = '0; cwd = '0; cra = '0; cse = 1'b0; csa = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_ab[i] = '0;
        for (int i = 0; i < 16; i++) m_c[i] = '0;
        b_ab = '0;
        b_c  = '0;
    endtask

    initial begin
        logic [63:0] ed;
        logic        eb;
        logic [31:0] ced;
        logic        ceb;

        idle_inputs();
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy_a", 64'(ifa.busy_vec), 64'h0);
        check("rst_rd_a", ifa.rd_data[0], 64'h0);
        check("rst_busy_c", 64'(ifc.busy_vec), 64'h0);
        rst_n = 1'b1;

        // Async reset mid-cycle
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 64'hAAAA; se = 1'b1; sa = 5'd4;
        @(negedge clk);
        we = 1'b0; se = 1'b0; ra[0] = 5'd3; ra[1] = 5'd4;
        #1;
        check("t1_pre_data", ifa.rd_data[0], 64'hAAAA);
        check("t1_pre_vec", 64'(ifa.busy_vec), 64'h10);
        check("t1_pre_busy", 64'(ifa.rd_busy[1]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_rst_data", ifa.rd_data[0], 64'h0);
        check("t1_rst_vec", 64'(ifa.busy_vec), 64'h0);
        check("t1_rst_busy", 64'(ifa.rd_busy[1]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write/read sweep, read back one cycle later
        for (int p = 0; p < 31; p++) begin
            @(negedge clk);
            we = 1'b1; wa = 5'(p); wd = 64'(p + 100);
            ra[0] = (p == 0) ? 5'd0 : 5'(p - 1);
            ra[1] = ra[0];
            #1;
            if (p > 0) begin
                check("t2_p0", ifa.rd_data[0], 64'(p + 99));
                check("t2_p1", ifb.rd_data[1], 64'(p + 99));
            end
        end
        @(negedge clk);
        we = 1'b0; ra[0] = 5'd30; ra[1] = 5'd31;
        #1;
        check("t2_r30", ifa.rd_data[0], 64'd130);
        check("t2_r31", ifa.rd_data[1], 64'h0);
        @(negedge clk);
        we = 1'b1; wa = 5'd31; wd = 64'hFFFF; ra[0] = 5'd31; ra[1] = 5'd0;
        #1;
        check("t2_z_byp", ifa.rd_data[0], 64'h0);
        check("t2_r0", ifa.rd_data[1], 64'd100);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("t2_z_after_a", ifa.rd_data[0], 64'h0);
        check("t2_z_after_b", ifb.rd_data[0], 64'h0);
        check("t2_vec", 64'(ifa.busy_vec), 64'h0);

        // Bypass
        @(negedge clk);
        we = 1'b1; wa = 5'd5; wd = 64'h1234; ra[0] = 5'd5; ra[1] = 5'd6;
        #1;
        check("t3_byp_a", ifa.rd_data[0], 64'h1234);
        check("t3_old_b", ifb.rd_data[0], 64'd105);
        check("t3_other", ifa.rd_data[1], 64'd106);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("t3_after_a", ifa.rd_data[0], 64'h1234);
        check("t3_after_b", ifb.rd_data[0], 64'h1234);

        // Scoreboard set / clear
        @(negedge clk);
        se = 1'b1; sa = 5'd7; ra[0] = 5'd7;
        #1;
        check("t4_notyet", 64'(ifa.rd_busy[0]), 64'h0);
        @(negedge clk);
        se = 1'b0;
        #1;
        check("t4_vec_a", 64'(ifa.busy_vec), 64'h80);
        check("t4_vec_b", 64'(ifb.busy_vec), 64'h80);
        check("t4_busy_a", 64'(ifa.rd_busy[0]), 64'h1);
        check("t4_busy_b", 64'(ifb.rd_busy[0]), 64'h1);
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 64'h77;
        #1;
        check("t4_wbusy_a", 64'(ifa.rd_busy[0]), 64'h0);
        check("t4_wbusy_b", 64'(ifb.rd_busy[0]), 64'h1);
        check("t4_wdata_a", ifa.rd_data[0], 64'h77);
        check("t4_wdata_b", ifb.rd_data[0], 64'd107);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("t4_clr_a", 64'(ifa.busy_vec), 64'h0);
        check("t4_clr_b", 64'(ifb.rd_busy[0]), 64'h0);
        check("t4_data_b", ifb.rd_data[0], 64'h77);

        // Set/clear collision, zero-register set
        @(negedge clk);
        se = 1'b1; sa = 5'd9; we = 1'b1; wa = 5'd9; wd = 64'h9999;
        ra[1] = 5'd9;
        #1;
        check("t5_byp", ifa.rd_data[1], 64'h9999);
        @(negedge clk);
        se = 1'b0; we = 1'b0;
        #1;
        check("t5_vec", 64'(ifa.busy_vec), 64'h200);
        check("t5_data", ifb.rd_data[1], 64'h9999);
        check("t5_busy", 64'(ifa.rd_busy[1]), 64'h1);
        @(negedge clk);
        se = 1'b1; sa = 5'd31; ra[0] = 5'd31;
        #1;
        check("t5_zbusy", 64'(ifa.rd_busy[0]), 64'h0);
        @(negedge clk);
        se = 1'b0;
        #1;
        check("t5_zvec", 64'(ifa.busy_vec), 64'h200);
        check("t5_zbusy2", 64'(ifa.rd_busy[0]), 64'h0);

        // Random sweep against the model
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = {32'($urandom), 32'($urandom)};
            se = 1'($urandom_range(0, 1));
            sa = 5'($urandom_range(0, 31));
            for (int p = 0; p < 2; p++)
                ra[p] = ($urandom_range(0, 3) == 0)
                        ? wa : 5'($urandom_range(0, 31));
            cwe = 1'($urandom_range(0, 1));
            cwa = 4'($urandom_range(0, 15));
            cwd = 32'($urandom);
            cse = 1'($urandom_range(0, 1));
            csa = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++)
                cra[p] = ($urandom_range(0, 3) == 0)
                         ? cwa : 4'($urandom_range(0, 15));
            #1;

            for (int p = 0; p < 2; p++) begin
                if (ra[p] == 5'd31) begin
                    ed = '0; eb = 1'b0;
                end else if (we && ra[p] == wa) begin
                    ed = wd; eb = 1'b0;
                end else begin
                    ed = m_ab[ra[p]]; eb = b_ab[ra[p]];
                end
                check("rnd_a_data", ifa.rd_data[p], ed);
                check("rnd_a_busy", 64'(ifa.rd_busy[p]), 64'(eb));
                if (ra[p] == 5'd31) begin
                    ed = '0; eb = 1'b0;
                end else begin
                    ed = m_ab[ra[p]]; eb = b_ab[ra[p]];
                end
                check("rnd_b_data", ifb.rd_data[p], ed);
                check("rnd_b_busy", 64'(ifb.rd_busy[p]), 64'(eb));
            end
            check("rnd_a_vec", 64'(ifa.busy_vec), 64'(b_ab));
            check("rnd_b_vec", 64'(ifb.busy_vec), 64'(b_ab));

            for (int p = 0; p < 3; p++) begin
                if (cra[p] == 4'd15) begin
                    ced = '0; ceb = 1'b0;
                end else if (cwe && cra[p] == cwa) begin
                    ced = cwd; ceb = 1'b0;
                end else begin
                    ced = m_c[cra[p]]; ceb = b_c[cra[p]];
                end
                check("rnd_c_data", 64'(ifc.rd_data[p]), 64'(ced));
                check("rnd_c_busy", 64'(ifc.rd_busy[p]), 64'(ceb));
            end
            check("rnd_c_vec", 64'(ifc.busy_vec), 64'(b_c));

            // State applied at the coming rising edge
            if (we && wa != 5'd31) m_ab[wa] = wd;
            if (we) b_ab[wa] = 1'b0;
            if (se && sa != 5'd31) b_ab[sa] = 1'b1;
            if (cwe && cwa != 4'd15) m_c[cwa] = cwd;
            if (cwe) b_c[cwa] = 1'b0;
            if (cse && csa != 4'd15) b_c[csa] = 1'b1;
        end

        @(negedge clk);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
